// File: rtl/dac_pkg.sv
// Shared types and default timing for the dual-channel DAC write scheduler.
package dac_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_DONE   = 3'd4,
      ST_LOAD   = 3'd5,
      ST_CLEAR  = 3'd6
   } dac_state_t;

   localparam int DAC_SETUP = 2;
   localparam int DAC_PULSE = 4;
   localparam int DAC_HOLD  = 2;

   localparam logic DAC_CH_A = 1'b0;
   localparam logic DAC_CH_B = 1'b1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/dac_rr_arbiter.sv
// Two-way round-robin arbiter; grant is one-hot and only asserted on advance.
module dac_rr_arbiter
   import dac_pkg::*;
(
   input  logic [1:0] req,
   input  logic       advance,
   input  logic       ptr,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (advance) begin
         unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (ptr == DAC_CH_B) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/dac_channel_scheduler.sv
// Arbitrates channel A/B writes onto a shared parallel DAC and sequences
// CS/WR/LDAC/CLR for each handshaked transaction.
module dac_channel_scheduler
   import dac_pkg::*;
#(
   parameter int DW        = 8,
   parameter int SETUP_CYC = DAC_SETUP,
   parameter int PULSE_CYC = DAC_PULSE,
   parameter int HOLD_CYC  = DAC_HOLD,
   parameter bit SYNC_LDAC = 1'b1
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          Enable,
   input  logic          ReqA,
   input  logic          ReqB,
   input  logic [DW-1:0] DataA,
   input  logic [DW-1:0] DataB,
   output logic          AckA,
   output logic          AckB,
   input  logic          ClrReq,
   output logic [DW-1:0] DB,
   output logic          CS,
   output logic          WR,
   output logic          LDAC,
   output logic          CLR,
   output logic          AB,
   output logic          PD,
   output logic          Busy
);

   localparam int CW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC)) + 1;
   localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] LD_PULSE = CW'(PULSE_CYC - 1);
   localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);

   dac_state_t    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          ptr;
   logic          pend;
   logic [1:0]    grant;
   logic          cnt_zero;
   logic          other_req;
   logic          load_go;
   logic          idle_grant;

   assign PD         = 1'b1;
   assign cnt_zero   = (cnt == '0);
   assign other_req  = (AB == DAC_CH_A) ? ReqB : ReqA;
   // A deferred load is never deferred twice: the owed LDAC goes out after this write.
   assign load_go    = !SYNC_LDAC || !other_req || pend;
   assign idle_grant = (state == ST_IDLE) && !ClrReq && Enable;

   dac_rr_arbiter u_arb (
      .req     ({ReqB, ReqA}),
      .advance (idle_grant),
      .ptr     (ptr),
      .grant   (grant)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (ClrReq)
               state_nxt = ST_CLEAR;
            else if (grant != 2'b00)
               state_nxt = ST_SETUP;
         end
         ST_SETUP:  if (cnt_zero) state_nxt = ST_STROBE;
         ST_STROBE: if (cnt_zero) state_nxt = ST_HOLD;
         ST_HOLD:   if (cnt_zero) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = load_go ? ST_LOAD : ST_IDLE;
         ST_LOAD:   state_nxt = ST_IDLE;
         ST_CLEAR:  if (cnt_zero) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_nxt = cnt_zero ? cnt : cnt - CW'(1);
      if (state_nxt != state) begin
         unique case (state_nxt)
            ST_SETUP:  cnt_nxt = LD_SETUP;
            ST_STROBE: cnt_nxt = LD_PULSE;
            ST_HOLD:   cnt_nxt = LD_HOLD;
            ST_CLEAR:  cnt_nxt = LD_PULSE;
            default:   cnt_nxt = '0;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         ptr   <= DAC_CH_A;
         pend  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (grant != 2'b00)
            ptr <= grant[0] ? DAC_CH_B : DAC_CH_A;
         if (state == ST_DONE && !load_go)
            pend <= 1'b1;
         else if (state == ST_LOAD || state == ST_CLEAR)
            pend <= 1'b0;
      end
   end

   // Pin strobes are decoded from the next state so every output is a flop.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         CS   <= 1'b1;
         WR   <= 1'b1;
         LDAC <= 1'b1;
         CLR  <= 1'b1;
         AB   <= DAC_CH_A;
         DB   <= '0;
         AckA <= 1'b0;
         AckB <= 1'b0;
         Busy <= 1'b0;
      end else begin
         CS   <= !(state_nxt inside {ST_SETUP, ST_STROBE, ST_HOLD});
         WR   <= (state_nxt != ST_STROBE);
         LDAC <= (state_nxt != ST_LOAD);
         CLR  <= (state_nxt != ST_CLEAR);
         AckA <= (state_nxt == ST_DONE) && (AB == DAC_CH_A);
         AckB <= (state_nxt == ST_DONE) && (AB == DAC_CH_B);
         Busy <= (state_nxt != ST_IDLE);
         if (grant[0]) begin
            DB <= DataA;
            AB <= DAC_CH_A;
         end else if (grant[1]) begin
            DB <= DataB;
            AB <= DAC_CH_B;
         end
      end
   end

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Directed scoreboard bench for dac_channel_scheduler (SYNC_LDAC=1 and 0 instances).
module tb_dac_channel_scheduler;
   import dac_pkg::*;

   localparam int DW = 8;

   typedef struct packed {
      logic          ch;
      logic [DW-1:0] data;
   } exp_t;

   logic          Clk = 1'b0;
   logic          Rst, Enable, ReqA, ReqB, ClrReq, sel;
   logic [DW-1:0] DataA, DataB;

   logic          AckA1, AckB1, CS1, WR1, LDAC1, CLR1, AB1, PD1, Busy1;
   logic          AckA0, AckB0, CS0, WR0, LDAC0, CLR0, AB0, PD0, Busy0;
   logic [DW-1:0] DB1, DB0;

   logic          ack_a_m, ack_b_m, cs_m, wr_m, ldac_m, clr_m, ab_m, busy_m;
   logic [DW-1:0] db_m;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic [DW-1:0] aq[$];
   logic [DW-1:0] bq[$];
   int   n_ldac, n_follow, n_clr, clr_first, cs_bad, ack_a_cyc, ack_b_cyc, ldac_cyc;

   always #5 Clk = ~Clk;

   dac_channel_scheduler #(.DW(DW), .SYNC_LDAC(1'b1)) u_dut1 (
      .Clk(Clk), .Rst(Rst), .Enable(Enable), .ReqA(ReqA), .ReqB(ReqB),
      .DataA(DataA), .DataB(DataB), .AckA(AckA1), .AckB(AckB1), .ClrReq(ClrReq),
      .DB(DB1), .CS(CS1), .WR(WR1), .LDAC(LDAC1), .CLR(CLR1), .AB(AB1), .PD(PD1), .Busy(Busy1)
   );

   dac_channel_scheduler #(.DW(DW), .SYNC_LDAC(1'b0)) u_dut0 (
      .Clk(Clk), .Rst(Rst), .Enable(Enable), .ReqA(ReqA), .ReqB(ReqB),
      .DataA(DataA), .DataB(DataB), .AckA(AckA0), .AckB(AckB0), .ClrReq(ClrReq),
      .DB(DB0), .CS(CS0), .WR(WR0), .LDAC(LDAC0), .CLR(CLR0), .AB(AB0), .PD(PD0), .Busy(Busy0)
   );

   assign ack_a_m = sel ? AckA1 : AckA0;
   assign ack_b_m = sel ? AckB1 : AckB0;
   assign cs_m    = sel ? CS1   : CS0;
   assign wr_m    = sel ? WR1   : WR0;
   assign ldac_m  = sel ? LDAC1 : LDAC0;
   assign clr_m   = sel ? CLR1  : CLR0;
   assign ab_m    = sel ? AB1   : AB0;
   assign busy_m  = sel ? Busy1 : Busy0;
   assign db_m    = sel ? DB1   : DB0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every Ack retires the oldest expected transaction.
   always @(negedge Clk) begin
      if (Rst === 1'b1 && (ack_a_m || ack_b_m)) begin
         chk("ack_onehot", 32'(ack_a_m & ack_b_m), 32'(0));
         chk("sb_nonempty", 32'(sb.size() > 0), 32'(1));
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("ack_ch", 32'(ack_b_m), 32'(mon_e.ch));
            chk("ack_ab", 32'(ab_m), 32'(mon_e.ch));
            chk("ack_db", 32'(db_m), 32'(mon_e.data));
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset(input logic s);
      sel    = s;
      Rst    = 1'b0;
      ReqA   = 1'b0;
      ReqB   = 1'b0;
      ClrReq = 1'b0;
      Enable = 1'b1;
      DataA  = '0;
      DataB  = '0;
      aq.delete();
      bq.delete();
      repeat (2) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
   endtask

   // Requester model: drop Req (or present the next queued sample) on Ack.
   task automatic run(input int maxc);
      logic prev_ack;
      logic done;
      n_ldac = 0; n_follow = 0; n_clr = 0; clr_first = 0; cs_bad = 0;
      ack_a_cyc = 0; ack_b_cyc = 0; ldac_cyc = 0;
      prev_ack = 1'b0;
      done = 1'b0;
      for (int cyc = 1; cyc <= maxc && !done; cyc++) begin
         @(negedge Clk);
         if (!ldac_m) begin
            n_ldac++;
            ldac_cyc = cyc;
            if (prev_ack) n_follow++;
         end
         if (!clr_m) begin
            n_clr++;
            if (clr_first == 0) clr_first = cyc;
            if (!cs_m) cs_bad++;
            ClrReq = 1'b0;
         end
         prev_ack = ack_a_m | ack_b_m;
         if (ack_a_m) begin
            ack_a_cyc = cyc;
            if (aq.size() > 0) begin
               DataA = aq.pop_front();
               sb.push_back('{ch: DAC_CH_A, data: DataA});
            end else ReqA = 1'b0;
         end
         if (ack_b_m) begin
            ack_b_cyc = cyc;
            if (bq.size() > 0) begin
               DataB = bq.pop_front();
               sb.push_back('{ch: DAC_CH_B, data: DataB});
            end else ReqB = 1'b0;
         end
         if (!ReqA && !ReqB && !ClrReq && !busy_m) done = 1'b1;
      end
      chk("run_done", 32'(done), 32'(1));
   endtask

   initial begin
      do_reset(1'b1);
      chk("rst_cs",   32'(CS1),   32'(1));
      chk("rst_wr",   32'(WR1),   32'(1));
      chk("rst_ldac", 32'(LDAC1), 32'(1));
      chk("rst_clr",  32'(CLR1),  32'(1));
      chk("rst_pd",   32'(PD1 & PD0), 32'(1));
      chk("rst_ab",   32'(AB1),   32'(0));
      chk("rst_db",   32'(DB1),   32'(0));
      chk("rst_ack",  32'(AckA1 | AckB1), 32'(0));
      chk("rst_busy", 32'(Busy1 | Busy0), 32'(0));

      // single write, cycle-exact strobe timing
      DataA = 8'hA5;
      ReqA  = 1'b1;
      sb.push_back('{ch: DAC_CH_A, data: 8'hA5});
      for (int c = 1; c <= 12; c++) begin
         @(negedge Clk);
         chk($sformatf("t1_cs_c%0d", c),   32'(cs_m),    32'(!(c >= 1 && c <= 8)));
         chk($sformatf("t1_wr_c%0d", c),   32'(wr_m),    32'(!(c >= 3 && c <= 6)));
         chk($sformatf("t1_ack_c%0d", c),  32'(ack_a_m), 32'(c == 9));
         chk($sformatf("t1_ldac_c%0d", c), 32'(ldac_m),  32'(c != 10));
         if (c == 1) begin
            chk("t1_db", 32'(db_m), 32'(8'hA5));
            chk("t1_ab", 32'(ab_m), 32'(DAC_CH_A));
         end
         if (ack_a_m) ReqA = 1'b0;
      end

      // simultaneous requests, deferred LDAC
      do_reset(1'b1);
      DataA = 8'h11; DataB = 8'h22; ReqA = 1'b1; ReqB = 1'b1;
      sb.push_back('{ch: DAC_CH_A, data: 8'h11});
      sb.push_back('{ch: DAC_CH_B, data: 8'h22});
      run(100);
      chk("t2_order",      32'(ack_a_cyc < ack_b_cyc), 32'(1));
      chk("t2_ldac_n",     32'(n_ldac), 32'(1));
      chk("t2_ldac_afterB", 32'(ldac_cyc), 32'(ack_b_cyc + 1));

      // simultaneous requests, LDAC after every write
      do_reset(1'b0);
      DataA = 8'h11; DataB = 8'h22; ReqA = 1'b1; ReqB = 1'b1;
      sb.push_back('{ch: DAC_CH_A, data: 8'h11});
      sb.push_back('{ch: DAC_CH_B, data: 8'h22});
      run(100);
      chk("t3_ldac_n",      32'(n_ldac),   32'(2));
      chk("t3_ldac_follow", 32'(n_follow), 32'(2));

      // B continuous, A arrives mid-write: B, A, B
      do_reset(1'b1);
      DataB = 8'h33; ReqB = 1'b1;
      sb.push_back('{ch: DAC_CH_B, data: 8'h33});
      bq.push_back(8'h55);
      repeat (4) @(negedge Clk);
      chk("t4_in_strobe", 32'(wr_m), 32'(0));
      DataA = 8'h44; ReqA = 1'b1;
      sb.push_back('{ch: DAC_CH_A, data: 8'h44});
      run(100);
      chk("t4_ldac_n", 32'(n_ldac), 32'(2));

      // clear requested during a write
      do_reset(1'b1);
      DataA = 8'h66; ReqA = 1'b1;
      sb.push_back('{ch: DAC_CH_A, data: 8'h66});
      repeat (3) @(negedge Clk);
      ClrReq = 1'b1;
      DataB = 8'h77; ReqB = 1'b1;
      sb.push_back('{ch: DAC_CH_B, data: 8'h77});
      run(100);
      chk("t5_clr_len",    32'(n_clr),  32'(4));
      chk("t5_cs_in_clr",  32'(cs_bad), 32'(0));
      chk("t5_clr_afterA", 32'(clr_first > ack_a_cyc), 32'(1));
      chk("t5_B_afterclr", 32'(ack_b_cyc > clr_first + 3), 32'(1));

      // asynchronous reset during STROBE
      do_reset(1'b1);
      DataA = 8'h88; ReqA = 1'b1;
      sb.push_back('{ch: DAC_CH_A, data: 8'h88});
      repeat (4) @(negedge Clk);
      chk("t6_in_strobe", 32'(wr_m), 32'(0));
      Rst = 1'b0;
      #1;
      chk("t6_cs",   32'(CS1),   32'(1));
      chk("t6_wr",   32'(WR1),   32'(1));
      chk("t6_ldac", 32'(LDAC1), 32'(1));
      chk("t6_clr",  32'(CLR1),  32'(1));
      chk("t6_db",   32'(DB1),   32'(0));
      chk("t6_busy", 32'(Busy1), 32'(0));
      @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      chk("t6_restart_cs", 32'(cs_m), 32'(0));
      chk("t6_restart_wr", 32'(wr_m), 32'(1));
      chk("t6_restart_db", 32'(db_m), 32'(8'h88));
      run(100);

      // Enable low blocks new grants
      do_reset(1'b1);
      Enable = 1'b0;
      DataB = 8'h99; ReqB = 1'b1;
      sb.push_back('{ch: DAC_CH_B, data: 8'h99});
      for (int c = 1; c <= 5; c++) begin
         @(negedge Clk);
         chk($sformatf("t7_busy_c%0d", c), 32'(busy_m), 32'(0));
         chk($sformatf("t7_cs_c%0d", c),   32'(cs_m),   32'(1));
      end
      Enable = 1'b1;
      run(100);

      chk("sb_drained", 32'(sb.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
